// File: rtl/draw_sched_pkg.sv
// Shared encodings for the draw scheduler: job kinds, FSM states, watchdog
// sizing and the fixed-priority job pick.
package draw_sched_pkg;

  typedef enum logic [2:0] {
    JOB_NONE,
    JOB_BLACK,
    JOB_LOSE,
    JOB_START,
    JOB_ROUND
  } job_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam int DEF_TIMEOUT = 131071;
  localparam int WD_W        = 17;

  // Pending-bit positions, bit order {round, start, lose, black}
  localparam int P_BLACK = 0;
  localparam int P_LOSE  = 1;
  localparam int P_START = 2;
  localparam int P_ROUND = 3;

  function automatic job_t pick_job(input logic [3:0] p);
    if (p[P_BLACK])      return JOB_BLACK;
    else if (p[P_LOSE])  return JOB_LOSE;
    else if (p[P_START]) return JOB_START;
    else if (p[P_ROUND]) return JOB_ROUND;
    else                 return JOB_NONE;
  endfunction

  function automatic logic [3:0] job_bit(input job_t j);
    case (j)
      JOB_BLACK: return 4'b0001;
      JOB_LOSE:  return 4'b0010;
      JOB_START: return 4'b0100;
      JOB_ROUND: return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Per-job watchdog: cleared at issue, counts while enabled, saturates at LIMIT.
module draw_watchdog
  import draw_sched_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WD_W-1:0] LIM = WD_W'(LIMIT);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   cnt <= '0;
    else if (clear)                cnt <= '0;
    else if (enable && cnt != LIM) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIM);

endmodule

// File: rtl/draw_scheduler.sv
// Queues game-FSM draw requests and issues them one at a time to text_display,
// holding round selectors for the whole draw and watching writeEn for completion.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int SEL_W          = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_round,
  input  logic             req_start,
  input  logic             req_lose,
  input  logic             req_black,
  input  logic [SEL_W-1:0] not_not_sel_in,
  input  logic [SEL_W-1:0] colour_logic_sel_in,
  input  logic [SEL_W-1:0] colour_sel_1_in,
  input  logic [SEL_W-1:0] colour_sel_2_in,
  input  logic             disp_write_en,
  output logic             draw_enable,
  output logic             start,
  output logic             lose,
  output logic             black,
  output logic [SEL_W-1:0] not_not_selector,
  output logic [SEL_W-1:0] colour_logic_selector,
  output logic [SEL_W-1:0] colour_selector_1,
  output logic [SEL_W-1:0] colour_selector_2,
  output logic             busy,
  output logic [3:0]       pending,
  output logic             job_done,
  output logic             job_timeout
);

  state_t state, state_n;
  job_t   job, job_n;

  logic [3:0]            req, clr;
  logic [3:0][SEL_W-1:0] shadow, sel_q;
  logic                  sel_load, wd_clr, wd_en, wd_exp;

  assign req = {req_round, req_start, req_lose, req_black};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      job     <= JOB_NONE;
      pending <= '0;
      shadow  <= '0;
      sel_q   <= '0;
    end else begin
      state   <= state_n;
      job     <= job_n;
      // a new request wins over the clear, so a same-kind request re-queues the job
      pending <= (pending & ~clr) | req;
      if (req_round)
        shadow <= {not_not_sel_in, colour_logic_sel_in, colour_sel_1_in, colour_sel_2_in};
      if (sel_load)
        sel_q <= shadow;
    end
  end

  always_comb begin
    state_n     = state;
    job_n       = job;
    clr         = '0;
    sel_load    = 1'b0;
    wd_clr      = 1'b0;
    job_done    = 1'b0;
    job_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          job_n    = pick_job(pending);
          clr      = job_bit(job_n);
          sel_load = (job_n == JOB_ROUND);
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        wd_clr  = 1'b1;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (wd_exp) begin
          job_timeout = 1'b1;
          job_n       = JOB_NONE;
          state_n     = IDLE;
        end else if (disp_write_en) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // writeEn stays high across all round phases, so its fall marks the end
        if (!disp_write_en) begin
          job_done = 1'b1;
          job_n    = JOB_NONE;
          state_n  = IDLE;
        end else if (wd_exp) begin
          job_timeout = 1'b1;
          job_n       = JOB_NONE;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign wd_en = (state == WAIT_ACK) || (state == WAIT_DONE);

  draw_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  assign draw_enable = (state == ISSUE) && (job == JOB_ROUND);
  assign start       = (state == ISSUE) && (job == JOB_START);
  assign lose        = (state == ISSUE) && (job == JOB_LOSE);
  assign black       = (state == ISSUE) && (job == JOB_BLACK);
  assign busy        = (state != IDLE);

  assign {not_not_selector, colour_logic_selector, colour_selector_1, colour_selector_2} = sel_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: a job-queue reference model plus a behavioural
// display that holds writeEn for a chosen length after each command.
module tb_draw_scheduler;

  localparam int SEL_W = 3;
  localparam int WD_TO = 100;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic             req_round = 1'b0, req_start = 1'b0, req_lose = 1'b0, req_black = 1'b0;
  logic [SEL_W-1:0] nn_in = '0, cl_in = '0, c1_in = '0, c2_in = '0;
  logic             disp_write_en = 1'b0;
  logic             draw_enable, start, lose, black, busy, job_done, job_timeout;
  logic [SEL_W-1:0] nn_sel, cl_sel, c1_sel, c2_sel;
  logic [3:0]       pending;

  // second instance with a short watchdog; its display never answers
  logic             wd_req = 1'b0, wd_zero = 1'b0;
  logic             wd_de, wd_start, wd_lose, wd_black, wd_busy, wd_done, wd_to;
  logic [SEL_W-1:0] wd_nn, wd_cl, wd_c1, wd_c2;
  logic [3:0]       wd_pend;

  draw_scheduler #(.SEL_W(SEL_W)) dut (
    .clock(clock), .resetn(resetn),
    .req_round(req_round), .req_start(req_start), .req_lose(req_lose), .req_black(req_black),
    .not_not_sel_in(nn_in), .colour_logic_sel_in(cl_in),
    .colour_sel_1_in(c1_in), .colour_sel_2_in(c2_in),
    .disp_write_en(disp_write_en),
    .draw_enable(draw_enable), .start(start), .lose(lose), .black(black),
    .not_not_selector(nn_sel), .colour_logic_selector(cl_sel),
    .colour_selector_1(c1_sel), .colour_selector_2(c2_sel),
    .busy(busy), .pending(pending), .job_done(job_done), .job_timeout(job_timeout)
  );

  draw_scheduler #(.TIMEOUT_CYCLES(WD_TO), .SEL_W(SEL_W)) dut_wd (
    .clock(clock), .resetn(resetn),
    .req_round(wd_zero), .req_start(wd_req), .req_lose(wd_zero), .req_black(wd_zero),
    .not_not_sel_in(nn_in), .colour_logic_sel_in(cl_in),
    .colour_sel_1_in(c1_in), .colour_sel_2_in(c2_in),
    .disp_write_en(wd_zero),
    .draw_enable(wd_de), .start(wd_start), .lose(wd_lose), .black(wd_black),
    .not_not_selector(wd_nn), .colour_logic_selector(wd_cl),
    .colour_selector_1(wd_c1), .colour_selector_2(wd_c2),
    .busy(wd_busy), .pending(wd_pend), .job_done(wd_done), .job_timeout(wd_to)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: pending set, idle flag, shadow and held selectors
  int          cyc, we_lo, we_hi, exp_done, next_len;
  logic [3:0]  m_pend, cur_cmd;
  bit          m_idle;
  logic [11:0] m_shadow, m_osel;
  logic [3:0]  issue_log[$];
  int          done_cnt, last_cmd_cyc;
  int          wd_issue, wd_to_cyc, wd_to_cnt, wd_done_cnt;

  function automatic logic [3:0] prio(input logic [3:0] p);
    if (p[0]) return 4'b0001;
    if (p[1]) return 4'b0010;
    if (p[2]) return 4'b0100;
    if (p[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_idle = 1'b1; m_shadow = '0; m_osel = '0; cur_cmd = '0;
    we_lo = 1; we_hi = 0; exp_done = -1;
  endtask

  // one clock cycle: entered just after a rising edge, leaves just after the next
  task automatic step(input logic [3:0] req, input logic [11:0] sin);
    logic [3:0] cmd, nsel;
    bit         done_now;
    {req_round, req_start, req_lose, req_black} = req;
    {nn_in, cl_in, c1_in, c2_in} = sin;
    disp_write_en = (cyc >= we_lo) && (cyc <= we_hi);
    @(negedge clock);
    cmd = {draw_enable, start, lose, black};
    chk("cmd", cmd, cur_cmd);
    chk("pending", pending, m_pend);
    chk("busy", busy, !m_idle);
    chk("sels", {nn_sel, cl_sel, c1_sel, c2_sel}, m_osel);
    chk("job_done", job_done, cyc == exp_done);
    chk("job_timeout", job_timeout, 0);
    if (job_done) done_cnt++;
    if (cmd != 0) last_cmd_cyc = cyc;
    if (wd_start) wd_issue = cyc;
    if (wd_to) begin wd_to_cnt++; wd_to_cyc = cyc; end
    if (wd_done) wd_done_cnt++;
    if (cur_cmd != 0) begin
      issue_log.push_back(cur_cmd);
      we_lo = cyc + 1; we_hi = cyc + next_len; exp_done = cyc + next_len + 1;
    end
    done_now = (cyc == exp_done);
    nsel = (m_idle && m_pend != 0) ? prio(m_pend) : 4'b0000;
    if (nsel[3]) m_osel = m_shadow;
    if (req[3]) m_shadow = sin;
    m_pend  = (m_pend & ~nsel) | req;
    m_idle  = (m_idle && nsel == 0) || done_now;
    cur_cmd = nsel;
    cyc++;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 12'h000);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || pending != 0) && n < bound) begin
      step(4'b0000, 12'h000);
      n++;
    end
    chk("wait_idle_bound", n < bound, 1);
  endtask

  task automatic hard_reset();
    resetn = 1'b0;
    {req_round, req_start, req_lose, req_black} = '0;
    disp_write_en = 1'b0;
    @(negedge clock);
    chk("rst_cmd", {draw_enable, start, lose, black}, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sels", {nn_sel, cl_sel, c1_sel, c2_sel}, 0);
    chk("rst_pulses", {job_done, job_timeout}, 0);
    chk("rst_wd_busy", wd_busy, 0);
    model_reset();
    @(posedge clock); #1;
    resetn = 1'b1;
    cyc++;
  endtask

  int n_black;

  initial begin
    cyc = 0; next_len = 5; done_cnt = 0; last_cmd_cyc = -1;
    wd_issue = -1; wd_to_cyc = -1; wd_to_cnt = 0; wd_done_cnt = 0;
    model_reset();
    @(posedge clock); #1;
    hard_reset();

    // round with sels 2/1/3/0, display busy for 64000 cycles
    begin
      int c0, d0;
      next_len = 64000; c0 = cyc; d0 = done_cnt;
      step(4'b1000, {3'd2, 3'd1, 3'd3, 3'd0});
      idle(2);
      chk("round_latency", last_cmd_cyc - c0, 2);
      chk("round_sels", {nn_sel, cl_sel, c1_sel, c2_sel}, 12'h458);
      wait_idle(64100);
      chk("round_done_cnt", done_cnt - d0, 1);
      chk("round_busy_end", busy, 0);
    end

    // lose+round together, black arrives during the lose draw
    next_len = 10; issue_log.delete();
    step(4'b1010, 12'h123);
    idle(4);
    step(4'b0001, 12'h000);
    wait_idle(200);
    chk("order_len", issue_log.size(), 3);
    if (issue_log.size() == 3) begin
      chk("order_0_lose", issue_log[0], 4'b0010);
      chk("order_1_black", issue_log[1], 4'b0001);
      chk("order_2_round", issue_log[2], 4'b1000);
    end

    // new round sels during an active round draw wait for the redraw
    next_len = 20; issue_log.delete();
    step(4'b1000, {3'd5, 3'd4, 3'd3, 3'd2});
    idle(6);
    step(4'b1000, {3'd1, 3'd1, 3'd1, 3'd1});
    idle(5);
    chk("hold_old_sels", {nn_sel, cl_sel, c1_sel, c2_sel}, 12'hB1A);
    wait_idle(200);
    chk("redraw_sels", {nn_sel, cl_sel, c1_sel, c2_sel}, 12'h249);
    chk("redraw_count", issue_log.size(), 2);

    // two black pulses 5 cycles apart merge into one queued job
    next_len = 30; issue_log.delete();
    step(4'b0100, 12'h000);
    idle(3);
    step(4'b0001, 12'h000);
    idle(4);
    step(4'b0001, 12'h000);
    wait_idle(200);
    n_black = 0;
    foreach (issue_log[i]) if (issue_log[i] == 4'b0001) n_black++;
    chk("merge_black_once", n_black, 1);
    chk("merge_pending_empty", pending, 0);

    // watchdog on the short-timeout instance
    wd_req = 1'b1;
    step(4'b0000, 12'h000);
    wd_req = 1'b0;
    idle(WD_TO + 20);
    chk("wd_timeout_cnt", wd_to_cnt, 1);
    chk("wd_no_done", wd_done_cnt, 0);
    chk("wd_latency_ok", (wd_to_cyc - wd_issue >= WD_TO) && (wd_to_cyc - wd_issue <= WD_TO + 2), 1);
    chk("wd_busy_end", wd_busy, 0);

    // reset while a draw sits in WAIT_DONE with more work pending
    next_len = 50;
    step(4'b0001, 12'h000);
    idle(5);
    step(4'b1100, 12'hFFF);
    idle(3);
    hard_reset();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] r;
      r[0] = ($urandom_range(0, 15) == 0);
      r[1] = ($urandom_range(0, 15) == 0);
      r[2] = ($urandom_range(0, 15) == 0);
      r[3] = ($urandom_range(0, 15) == 0);
      next_len = $urandom_range(1, 15);
      step(r, 12'($urandom));
    end
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL tb_watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
